// File: rtl/spi_lens_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_lens_seq
// Purpose  : Turns one host register access into SPI_driver FIFO pushes.
//            A write pushes an address byte and a data byte. A read pushes an
//            address byte and an RX command, then pops the RX FIFO.
// Revision : 1.0  initial release
// ============================================================================
module spi_lens_seq #(
    parameter logic [15:0] ACK_WAIT  = 16'd1,
    parameter logic [7:0]  START_TMO = 8'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        command_read,
    output logic        tx_read,
    output logic        rx_read,
    output logic [1:0]  Spi_rw,
    output logic [7:0]  Spi_tx_reg,
    output logic [15:0] Spi_wait_reg,
    input  logic        busy,
    input  logic [7:0]  Spi_rx_reg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PUSH_A     = 3'd1,
        PUSH_B     = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4,
        RX_POP     = 3'd5,
        RX_CAP     = 3'd6,
        RESP       = 3'd7
    } state_t;

    localparam logic [1:0] c_rw_tx = 2'b01;
    localparam logic [1:0] c_rw_rx = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_write;
    logic [7:0]  r_wdata;
    logic [7:0]  r_tmo_cnt;
    logic [7:0]  r_rdata;
    logic        r_err;
    logic [1:0]  r_rw;
    logic [7:0]  r_tx;
    logic        w_tmo_expire;

    assign Spi_wait_reg = ACK_WAIT;
    assign Spi_rw       = r_rw;
    assign Spi_tx_reg   = r_tx;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        command_read = 1'b0;
        tx_read      = 1'b0;
        rx_read      = 1'b0;
        w_tmo_expire = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = PUSH_A;
                end
            end
            PUSH_A: begin
                command_read = 1'b1;
                tx_read      = 1'b1;
                w_state_nxt  = PUSH_B;
            end
            PUSH_B: begin
                command_read = 1'b1;
                tx_read      = r_write;
                w_state_nxt  = WAIT_START;
            end
            WAIT_START: begin
                // Expire on the cycle the count reaches zero, so the response
                // lands exactly START_TMO+1 cycles after PUSH_B.
                if (busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_tmo_cnt <= 8'd1) begin
                    w_tmo_expire = 1'b1;
                    w_state_nxt  = RESP;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    w_state_nxt = r_write ? RESP : RX_POP;
                end
            end
            RX_POP: begin
                rx_read     = 1'b1;
                w_state_nxt = RX_CAP;
            end
            RX_CAP: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command code and TX byte are registered on entry to each push state so
    // they line up with the push pulses and hold between pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_wdata   <= 8'h00;
            r_tmo_cnt <= 8'h00;
            r_rdata   <= 8'h00;
            r_err     <= 1'b0;
            r_rw      <= 2'b00;
            r_tx      <= 8'h00;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_write <= req_write;
                r_wdata <= req_wdata;
                r_rdata <= 8'h00;
                r_err   <= 1'b0;
                r_rw    <= c_rw_tx;
                r_tx    <= {~req_write, req_addr};
            end
            if (r_state == PUSH_A) begin
                r_rw <= r_write ? c_rw_tx : c_rw_rx;
                if (r_write) begin
                    r_tx <= r_wdata;
                end
            end
            if (r_state == PUSH_B) begin
                r_tmo_cnt <= START_TMO;
            end else if (r_state == WAIT_START && !busy && r_tmo_cnt != 8'h00) begin
                r_tmo_cnt <= r_tmo_cnt - 8'd1;
            end
            if (w_tmo_expire) begin
                r_err <= 1'b1;
            end
            if (r_state == RX_CAP) begin
                r_rdata <= Spi_rx_reg;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_lens_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_lens_seq
// Purpose  : Randomized scoreboard bench for spi_lens_seq with a lens-register
//            device model standing in for the SPI driver.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_lens_seq;

    localparam logic [7:0] START_TMO = 8'd15;
    localparam int         N_RAND    = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr = 7'h00;
    logic [7:0]  req_wdata = 8'h00;
    logic        busy = 1'b0;
    logic [7:0]  Spi_rx_reg = 8'h00;

    logic        req_ready, rsp_valid, rsp_err, command_read, tx_read, rx_read;
    logic [7:0]  rsp_rdata, Spi_tx_reg;
    logic [1:0]  Spi_rw;
    logic [15:0] Spi_wait_reg;

    logic        w2_req_ready, w2_rsp_valid, w2_rsp_err, w2_command_read, w2_tx_read, w2_rx_read;
    logic [7:0]  w2_rsp_rdata, w2_Spi_tx_reg;
    logic [1:0]  w2_Spi_rw;
    logic [15:0] w2_Spi_wait_reg;

    spi_lens_seq #(.ACK_WAIT(16'd1), .START_TMO(START_TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .command_read(command_read), .tx_read(tx_read), .rx_read(rx_read),
        .Spi_rw(Spi_rw), .Spi_tx_reg(Spi_tx_reg), .Spi_wait_reg(Spi_wait_reg),
        .busy(busy), .Spi_rx_reg(Spi_rx_reg)
    );

    spi_lens_seq #(.ACK_WAIT(16'd300), .START_TMO(START_TMO)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w2_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(w2_rsp_valid), .rsp_rdata(w2_rsp_rdata), .rsp_err(w2_rsp_err),
        .command_read(w2_command_read), .tx_read(w2_tx_read), .rx_read(w2_rx_read),
        .Spi_rw(w2_Spi_rw), .Spi_tx_reg(w2_Spi_tx_reg), .Spi_wait_reg(w2_Spi_wait_reg),
        .busy(busy), .Spi_rx_reg(Spi_rx_reg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] rw; logic [7:0] tx; logic txr; } push_t;
    typedef struct { logic [7:0] rdata; logic err; int n_rx; logic tmo; } rsp_t;

    push_t exp_push[$];
    rsp_t  exp_rsp[$];
    int    n_checks = 0;
    int    n_errors = 0;

    logic [7:0] ref_mem [128];
    bit         drv_mute = 1'b0;
    bit         drv_long = 1'b0;
    int         drv_phase = 0;
    int         rsp_cyc = -10;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 37) ^ 8'h5A;
        if (i == 5) v = 8'h3C;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lens device behind the SPI driver: decodes the two pushed bytes and
    // answers reads from its own register array.
    initial begin
        logic [7:0] lens_mem [128];
        logic [7:0] b0, b1, pend;
        logic       b1_tx;
        int         ncmd, dly, bcnt;
        for (int i = 0; i < 128; i++) lens_mem[i] = init_val(i);
        ncmd = 0; dly = 0; bcnt = 0; b0 = 0; b1 = 0; b1_tx = 0; pend = 0;
        forever begin
            @(negedge clk);
            if (drv_phase == 1) begin
                dly--;
                if (dly == 0) begin
                    busy = 1'b1;
                    Spi_rx_reg = 8'($urandom);
                    bcnt = drv_long ? 20 : int'($urandom_range(1, 8));
                    drv_phase = 2;
                end
            end else if (drv_phase == 2) begin
                bcnt--;
                if (bcnt == 0) begin
                    busy = 1'b0;
                    drv_phase = 0;
                    if (b0[7]) pend = lens_mem[b0[6:0]];
                    else if (b1_tx) lens_mem[b0[6:0]] = b1;
                end
            end
            if (rx_read) Spi_rx_reg = pend;
            if (command_read) begin
                if (ncmd == 0) b0 = Spi_tx_reg;
                else begin b1 = Spi_tx_reg; b1_tx = tx_read; end
                ncmd++;
                if (ncmd == 2) begin
                    ncmd = 0;
                    if (!drv_mute) begin
                        drv_phase = 1;
                        dly = int'($urandom_range(1, int'(START_TMO)));
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT pushes or responds.
    initial begin
        push_t p;
        rsp_t  r;
        int    cmd_n, rx_n, pushb_cyc;
        cmd_n = 0; rx_n = 0; pushb_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_n = 0; rx_n = 0;
            end else begin
                if (command_read) begin
                    if (exp_push.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL push_unexpected: got command_read=1 required no push (cycle %0d)", cyc);
                    end else begin
                        p = exp_push.pop_front();
                        check("push_rw", Spi_rw, p.rw);
                        check("push_tx_byte", Spi_tx_reg, p.tx);
                        check("push_tx_read", tx_read, p.txr);
                    end
                    check("wait_reg_1", Spi_wait_reg, 1);
                    check("wait_reg_300", w2_Spi_wait_reg, 300);
                    check("dut2_cmd_pulse", w2_command_read, 1);
                    cmd_n++;
                    pushb_cyc = cyc;
                end else if (tx_read) begin
                    check("tx_without_cmd", command_read, 1);
                end
                if (rx_read) rx_n++;
                if (rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 required 0 (cycle %0d)", cyc);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_rdata", rsp_rdata, r.rdata);
                        check("rsp_err", rsp_err, r.err);
                        check("rx_pulse_count", rx_n, r.n_rx);
                        check("cmd_pulse_count", cmd_n, 2);
                        if (r.tmo) check("tmo_latency", cyc - pushb_cyc, int'(START_TMO) + 1);
                    end
                    check("dut2_rsp_pulse", w2_rsp_valid, 1);
                    cmd_n = 0; rx_n = 0;
                    rsp_cyc = cyc;
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [6:0] a, input logic [7:0] d,
                         input bit tmo, input bit want_rsp, input bit keep, input bit b2b);
        push_t p;
        rsp_t  r;
        int    n;
        drv_mute  = tmo;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        p.rw = 2'b01; p.tx = {~w, a}; p.txr = 1'b1;
        exp_push.push_back(p);
        if (w) p.tx = d;
        else begin p.rw = 2'b10; p.txr = 1'b0; end
        exp_push.push_back(p);
        r.tmo   = tmo;
        r.err   = tmo;
        r.n_rx  = (!w && !tmo) ? 1 : 0;
        r.rdata = (!w && !tmo) ? ref_mem[a] : 8'h00;
        if (w && !tmo) ref_mem[a] = d;
        if (want_rsp) exp_rsp.push_back(r);
        n = 0;
        while (!req_ready && n < 400) begin @(negedge clk); n++; end
        check("req_accept", req_ready, 1);
        if (b2b) check("b2b_accept_after_resp", cyc - rsp_cyc, 1);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_rsp.size() == 0 && !busy && drv_phase == 0 && req_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++; n_errors++;
            $display("FAIL wait_idle: got pending=%0d busy=%0b required idle", exp_rsp.size(), busy);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_command_read", command_read, 0);
        check("rst_tx_read", tx_read, 0);
        check("rst_rx_read", rx_read, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_spi_rw", Spi_rw, 0);
        check("rst_spi_tx_reg", Spi_tx_reg, 0);
        check("rst_wait_reg", Spi_wait_reg, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        issue(1'b1, 7'h12, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b0, 7'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b0, 7'h33, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b1, 7'h40, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b0, 7'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle();

        issue(1'b1, 7'h21, 8'h9E, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 7'h22, 8'h4B, 1'b0, 1'b1, 1'b0, 1'b1); wait_idle();
        issue(1'b0, 7'h21, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle();
        issue(1'b0, 7'h22, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle();

        drv_long = 1'b1;
        issue(1'b1, 7'h0A, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        check("rst_test_busy_seen", busy, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        wait_idle();
        drv_long = 1'b0;
        issue(1'b0, 7'h0A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); wait_idle();

        for (int k = 0; k < N_RAND; k++) begin
            issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 5) == 0), 1'b1, 1'b0, 1'b0);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("push_queue_drained", exp_push.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion required finish within 1ms");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_lens_seq.md
SPI_LENS_SEQ -- requirements
Module: spi_lens_seq

Interface
REQ-001 SHALL have parameter ACK_WAIT, default 16'd1, meaning the SPI_driver post-TX acknowledge wait count placed on Spi_wait_reg for every command.
REQ-002 SHALL have parameter START_TMO, default 8'd15, meaning the maximum cycles to wait for busy to rise after the last push.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  host register-access request.
REQ-007 req_ready  out  1  high when IDLE; the request is accepted on req_valid&&req_ready.
REQ-008 req_write  in  1  1 = register write, 0 = register read.
REQ-009 req_addr  in  7  lens register address.
REQ-010 req_wdata  in  8  write data; ignored for reads.
REQ-011 rsp_valid  out  1  one-cycle pulse; the transaction is complete.
REQ-012 rsp_rdata  out  8  read data; 8'h00 for writes.
REQ-013 rsp_err  out  1  qualified by rsp_valid; set on a start timeout.
REQ-014 command_read  out  1  push pulse to the driver command/wait FIFOs.
REQ-015 tx_read  out  1  push pulse to the driver TX FIFO.
REQ-016 rx_read  out  1  pop pulse to the driver RX FIFO.
REQ-017 Spi_rw  out  2  command code: 2'b01 = TX byte, 2'b10 = RX byte.
REQ-018 Spi_tx_reg  out  8  TX byte.
REQ-019 Spi_wait_reg  out  16  equals ACK_WAIT at all times.
REQ-020 busy  in  1  driver busy flag.
REQ-021 Spi_rx_reg  in  8  driver RX data, valid the cycle after an rx_read pulse.

Function
REQ-022 States SHALL be IDLE, PUSH_A, PUSH_B, WAIT_START, WAIT_DONE, RX_POP, RX_CAP and RESP.
REQ-023 IDLE: on accept, the block SHALL latch write, addr and wdata, clear rsp_err and go to PUSH_A; the first push occurs one cycle after accept.
REQ-024 PUSH_A: for one cycle, command_read=1, tx_read=1, Spi_rw=01 and Spi_tx_reg={~write,addr}; next state PUSH_B.
- Bit7=1 marks a read.
REQ-025 PUSH_B, write request: for one cycle, command_read=1, tx_read=1, Spi_rw=01 and Spi_tx_reg=wdata.
REQ-026 PUSH_B, read request: for one cycle, command_read=1, tx_read=0 and Spi_rw=10.
REQ-027 PUSH_B SHALL always go to WAIT_START and load the timeout counter with START_TMO.
REQ-028 The TX byte and its command SHALL be pushed in the same cycle, so the TX FIFO is never empty when the driver enters TX.
REQ-029 WAIT_START: busy=1 → WAIT_DONE.
- Otherwise the counter decrements each cycle.
- At 0 with busy=0: rsp_err=1, go to RESP.
REQ-030 WAIT_DONE: busy=0 → RX_POP for reads, RESP for writes.
- There is no upper bound on WAIT_DONE.
REQ-031 RX_POP SHALL assert rx_read for exactly one cycle, then go to RX_CAP.
REQ-032 RX_CAP SHALL register Spi_rx_reg into rsp_rdata, then go to RESP.
REQ-033 RESP SHALL assert rsp_valid for one cycle, then return to IDLE.
REQ-034 command_read, tx_read, rx_read and rsp_valid SHALL be single-cycle pulses, 0 in every state not listed above.
REQ-035 At most one transaction SHALL be outstanding: 2 commands and ≤2 TX bytes, so driver FIFO depth 16 never overflows.
REQ-036 A write SHALL set rsp_rdata to 8'h00.
REQ-037 A timeout SHALL not issue rx_read and SHALL return rsp_rdata=8'h00.
REQ-038 req_valid asserted outside IDLE SHALL be ignored (req_ready=0), with no internal queuing.
REQ-039 Spi_tx_reg and Spi_rw SHALL hold their last values when no push is active.

Reset
REQ-040 While rst=1 at a clk edge: state=IDLE, all pulses=0, rsp_rdata=8'h00, rsp_err=0, Spi_rw=2'b00, Spi_tx_reg=8'h00, timeout counter=0.
REQ-041 The first cycle after rst deassertion, req_ready SHALL be 1.
REQ-042 Reset mid-transaction SHALL abandon it with no rsp_valid.
- The driver has no reset; the bench SHALL let driver busy fall before issuing a new request.

Verification
REQ-043 Write: addr=7'h12, wdata=8'hA5 → PUSH_A Spi_tx_reg=8'h12; PUSH_B Spi_tx_reg=8'hA5; both with Spi_rw=01. After busy rises then falls, rsp_valid=1, rsp_err=0, rsp_rdata=8'h00.
REQ-044 Read: addr=7'h05, driver model returns 8'h3C → PUSH_A Spi_tx_reg=8'h85; PUSH_B Spi_rw=10, tx_read=0. After busy falls, exactly one rx_read pulse, then rsp_rdata=8'h3C, rsp_err=0.
REQ-045 Start timeout: busy held 0 → rsp_valid exactly START_TMO+1 cycles after PUSH_B, rsp_err=1, no rx_read.
REQ-046 Back-to-back: req_valid held high across two writes → second accepted only after RESP; never more than 2 command_read pulses per transaction.
REQ-047 Reset in WAIT_DONE: rst pulsed → no rsp_valid; req_ready=1 the next cycle; all outputs at reset values.
REQ-048 Spi_wait_reg equals ACK_WAIT on every command_read pulse (check ACK_WAIT=16'd1 and 16'd300).
